// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency word write / 4-word line read behind a
// request/ready handshake. Optional protocol checker under DMEM_PROTOCOL_CHECK_EN.
module dmem_responder #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         MemRead_en,
  input  logic         MemWrite_en,
  input  logic [9:0]   address,
  input  logic [31:0]  wdata,
  output logic         ready,
  output logic [127:0] rdata_line,
  output logic         busy,
  output logic         err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         is_wr_q, is_wr_d;
  logic [9:0]   addr_q, addr_d;
  logic         ready_q;
  logic [127:0] rdata_q;
  logic         commit_c;
  logic [127:0] line_c;

  logic [31:0]  mem [DEPTH_WORDS];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    commit_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemRead_en || MemWrite_en) begin
          is_wr_d = !MemRead_en;  // read wins when both are raised
          addr_d  = address;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (is_wr_q ? !MemWrite_en : !MemRead_en) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          commit_c = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = (MemRead_en || MemWrite_en) ? HOLD : IDLE;
      HOLD: if (!MemRead_en && !MemWrite_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      ready_q <= commit_c;
      if (commit_c && !is_wr_q) rdata_q <= line_c;
    end
  end

  // Upper address bits beyond the array size are dropped by the AW-bit casts.
  always_comb begin
    line_c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      line_c[32*k +: 32] = mem[AW'({addr_q[9:2], 2'(k)})];
    end
  end

  always_ff @(posedge clock) begin
    if (commit_c && is_wr_q) mem[AW'(addr_q)] <= wdata;
  end

  assign ready      = ready_q;
  assign rdata_line = rdata_q;
  assign busy       = (state_q != IDLE);

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic err_q;
  logic viol_c;

  always_comb begin
    viol_c = 1'b0;
    if (state_q == IDLE && MemRead_en && MemWrite_en) viol_c = 1'b1;
    if (state_q == WAIT && ((address != addr_q) || (is_wr_q ? MemRead_en : MemWrite_en)))
      viol_c = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | viol_c;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
